// File: rtl/pti_ddr_lane_serializer_if.sv
// rtl/pti_ddr_lane_serializer_if.sv - trace word valid/ready handshake bundle
// master drives the word, slave (the serializer) returns oReady.
interface pti_ddr_lane_serializer_if #(
  parameter int WORD_WIDTH = 32
);
  logic [WORD_WIDTH-1:0] iData;
  logic                  iValid;
  logic                  oReady;

  modport master (output iData, output iValid, input oReady);
  modport slave  (input iData, input iValid, output oReady);
endinterface

// File: rtl/pti_ddr_lane_serializer.sv
// rtl/pti_ddr_lane_serializer.sv - slices trace words into per-lane DDR pairs for the PTI IODs
// Optional training pattern while idle: define PTI_TRAIN_PATTERN_EN.
module pti_ddr_lane_serializer #(
  parameter int LANES      = 4,
  parameter int WORD_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                        iClk,
  input  logic                        iRstN,
  input  logic                        iEnable,
  pti_ddr_lane_serializer_if.slave    wordBus,
  input  logic                        iTrain,
  output logic [2*LANES-1:0]          oLaneData,
  output logic [1:0]                  oClkData,
  output logic                        oActive,
  output logic [CNT_WIDTH-1:0]        oUnderrunCnt
);
  localparam int PAIR  = 2 * LANES;
  localparam int BEATS = WORD_WIDTH / PAIR;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic {IDLE, SHIFT} stateE;

  stateE                 state, nextState;
  logic [BW-1:0]         beatCnt;
  logic [WORD_WIDTH-1:0] shiftReg;
  logic                  lastBeat;
  logic                  accept;
  logic                  underrun;
  logic                  trainIdle;
  logic [PAIR-1:0]       idlePattern;

`ifdef PTI_TRAIN_PATTERN_EN
  assign trainIdle = iTrain;
`else
  logic unusedTrain;
  assign unusedTrain = iTrain;
  assign trainIdle   = 1'b0;
`endif

  // Each lane sends 2'b10 (first edge 0, second edge 1) as the deskew pattern.
  assign idlePattern = trainIdle ? {LANES{2'b10}} : '0;
  assign lastBeat    = (beatCnt == LAST_BEAT);
  assign accept      = wordBus.iValid && wordBus.oReady;
  assign underrun    = (state == SHIFT) && lastBeat && !accept && iEnable;

  // The low LANES bits of a raw beat go out on the first edge of every lane.
  function automatic logic [PAIR-1:0] mapBeat(input logic [PAIR-1:0] raw);
    logic [PAIR-1:0] res;
    res = '0;
    for (int k = 0; k < LANES; k++) begin
      res[2*k]   = raw[k];
      res[2*k+1] = raw[LANES+k];
    end
    return res;
  endfunction

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState      = state;
    wordBus.oReady = 1'b0;
    case (state)
      IDLE: begin
        wordBus.oReady = iEnable && !trainIdle;
        if (wordBus.iValid && iEnable && !trainIdle) nextState = SHIFT;
      end
      SHIFT: begin
        wordBus.oReady = iEnable && lastBeat;
        if (lastBeat && !(wordBus.iValid && iEnable)) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      beatCnt      <= '0;
      shiftReg     <= '0;
      oLaneData    <= '0;
      oClkData     <= 2'b00;
      oActive      <= 1'b0;
      oUnderrunCnt <= '0;
    end else begin
      oClkData <= 2'b10;
      if (accept) begin
        beatCnt   <= '0;
        oLaneData <= mapBeat(wordBus.iData[PAIR-1:0]);
        shiftReg  <= wordBus.iData >> PAIR;
        oActive   <= 1'b1;
      end else if (state == SHIFT && !lastBeat) begin
        beatCnt   <= beatCnt + 1'b1;
        oLaneData <= mapBeat(shiftReg[PAIR-1:0]);
        shiftReg  <= shiftReg >> PAIR;
        oActive   <= 1'b1;
      end else begin
        beatCnt   <= '0;
        oLaneData <= idlePattern;
        oActive   <= 1'b0;
      end
      if (underrun && oUnderrunCnt != '1) oUnderrunCnt <= oUnderrunCnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_pti_ddr_lane_serializer.sv
// tb/tb_pti_ddr_lane_serializer.sv - vector table, corner sequences and random run against a beat-queue model
// Build with or without PTI_TRAIN_PATTERN_EN.
module tb_pti_ddr_lane_serializer;
  localparam int LANES = 4;
  localparam int WW    = 32;
  localparam int BEATS = WW / (2 * LANES);
`ifdef PTI_TRAIN_PATTERN_EN
  localparam bit TRAIN = 1'b1;
`else
  localparam bit TRAIN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic en = 1'b0;
  logic train = 1'b0;
  logic [7:0]  lane, satLane;
  logic [1:0]  clkData, satClk;
  logic        act, satAct;
  logic [15:0] cnt;
  logic [1:0]  satCnt;

  always #5 clk = ~clk;

  pti_ddr_lane_serializer_if #(.WORD_WIDTH(WW)) bus ();
  pti_ddr_lane_serializer_if #(.WORD_WIDTH(WW)) satBus ();
  assign satBus.iData  = bus.iData;
  assign satBus.iValid = bus.iValid;

  pti_ddr_lane_serializer #(.LANES(LANES), .WORD_WIDTH(WW), .CNT_WIDTH(16)) dut (
    .iClk(clk), .iRstN(rstN), .iEnable(en), .wordBus(bus), .iTrain(train),
    .oLaneData(lane), .oClkData(clkData), .oActive(act), .oUnderrunCnt(cnt)
  );

  pti_ddr_lane_serializer #(.LANES(LANES), .WORD_WIDTH(WW), .CNT_WIDTH(2)) satDut (
    .iClk(clk), .iRstN(rstN), .iEnable(en), .wordBus(satBus), .iTrain(train),
    .oLaneData(satLane), .oClkData(satClk), .oActive(satAct), .oUnderrunCnt(satCnt)
  );

  int nChecks = 0;
  int nErrors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: a queue of the beats still owed for the current word.
  bit         mActive;
  logic [7:0] mLane;
  logic [7:0] beatsQ[$];
  int         mCnt, mSat;

  function automatic logic [7:0] beatOf(input logic [31:0] w, input int b);
    logic [7:0] r;
    r = '0;
    for (int k = 0; k < LANES; k++)
      for (int e = 0; e < 2; e++)
        r[2*k+e] = w[b*2*LANES + e*LANES + k];
    return r;
  endfunction

  function automatic bit modelReady();
    return en && (!mActive || beatsQ.size() == 0) && !(TRAIN && train && !mActive);
  endfunction

  task automatic modelReset();
    mActive = 1'b0;
    mLane   = '0;
    beatsQ.delete();
    mCnt    = 0;
    mSat    = 0;
  endtask

  task automatic modelEdge(input bit acc);
    if (acc) begin
      mLane = beatOf(bus.iData, 0);
      beatsQ.delete();
      for (int b = 1; b < BEATS; b++) beatsQ.push_back(beatOf(bus.iData, b));
      mActive = 1'b1;
    end else if (mActive && beatsQ.size() > 0) begin
      mLane = beatsQ.pop_front();
    end else begin
      if (mActive && en) begin
        if (mCnt < 65535) mCnt++;
        if (mSat < 3) mSat++;
      end
      mActive = 1'b0;
      mLane   = (TRAIN && train) ? 8'hAA : 8'h00;
    end
  endtask

  task automatic doReset();
    rstN = 1'b0; en = 1'b0; train = 1'b0; bus.iValid = 1'b0; bus.iData = '0;
    step();
    step();
    rstN = 1'b1;
    step();
    modelReset();
  endtask

  typedef struct {
    logic        en;
    logic        valid;
    logic [31:0] data;
    logic        expReady;
    logic [7:0]  expLane;
    logic        expAct;
    int          expCnt;
  } vecT;

  vecT vecs[$];

  function automatic vecT mk(input logic e, input logic v, input logic [31:0] d,
                             input logic r, input logic [7:0] l, input logic a, input int c);
    vecT t;
    t.en = e; t.valid = v; t.data = d; t.expReady = r; t.expLane = l; t.expAct = a; t.expCnt = c;
    return t;
  endfunction

  localparam logic [31:0] W = 32'h7654_3210;

  initial begin
    bit hold;
    bit r;
    bit acc;

    bus.iValid = 1'b0;
    bus.iData  = '0;
    modelReset();

    #12;
    chk("rst_lane", lane, 8'h00);
    chk("rst_clk", clkData, 2'b00);
    chk("rst_active", act, 1'b0);
    chk("rst_cnt", cnt, 0);
    rstN = 1'b1;
    step();
    chk("clk_after_rst", clkData, 2'b10);
    chk("idle_lane", lane, 8'h00);

    // Single word, then three back-to-back words.
    vecs.push_back(mk(1, 1, W, 1, 8'h02, 1, 0));
    vecs.push_back(mk(1, 0, W, 0, 8'h0E, 1, 0));
    vecs.push_back(mk(1, 0, W, 0, 8'h32, 1, 0));
    vecs.push_back(mk(1, 0, W, 0, 8'h3E, 1, 0));
    vecs.push_back(mk(1, 0, W, 1, 8'h00, 0, 1));
    vecs.push_back(mk(1, 0, W, 1, 8'h00, 0, 1));
    vecs.push_back(mk(1, 1, 32'hFFFF_FFFF, 1, 8'hFF, 1, 1));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 1, 32'h0, 0, 8'hFF, 1, 1));
    vecs.push_back(mk(1, 1, 32'h0, 1, 8'h00, 1, 1));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 1, W, 0, 8'h00, 1, 1));
    vecs.push_back(mk(1, 1, W, 1, 8'h02, 1, 1));
    vecs.push_back(mk(1, 0, W, 0, 8'h0E, 1, 1));
    vecs.push_back(mk(1, 0, W, 0, 8'h32, 1, 1));
    vecs.push_back(mk(1, 0, W, 0, 8'h3E, 1, 1));
    vecs.push_back(mk(1, 0, W, 1, 8'h00, 0, 2));
    vecs.push_back(mk(1, 0, W, 1, 8'h00, 0, 2));

    foreach (vecs[i]) begin
      en = vecs[i].en; bus.iValid = vecs[i].valid; bus.iData = vecs[i].data;
      #1;
      chk($sformatf("vec%0d_ready", i), bus.oReady, vecs[i].expReady);
      step();
      chk($sformatf("vec%0d_lane", i), lane, vecs[i].expLane);
      chk($sformatf("vec%0d_active", i), act, vecs[i].expAct);
      chk($sformatf("vec%0d_cnt", i), cnt, vecs[i].expCnt);
    end

    // iEnable dropped while beat 1 is on the pins.
    en = 1'b1; bus.iValid = 1'b1; bus.iData = W;
    step();
    bus.iValid = 1'b0;
    step();
    chk("endrop_beat1", lane, 8'h0E);
    en = 1'b0;
    for (int b = 2; b < BEATS; b++) begin
      #1;
      chk($sformatf("endrop_ready_b%0d", b - 1), bus.oReady, 1'b0);
      step();
      chk($sformatf("endrop_beat%0d", b), lane, beatOf(W, b));
      chk($sformatf("endrop_active%0d", b), act, 1'b1);
    end
    #1;
    chk("endrop_ready_last", bus.oReady, 1'b0);
    step();
    chk("endrop_idle", lane, 8'h00);
    chk("endrop_cnt", cnt, 2);

    // Reset asserted while beat 2 is on the pins.
    en = 1'b1; bus.iValid = 1'b1; bus.iData = W;
    step();
    bus.iValid = 1'b0;
    step();
    step();
    chk("rstmid_beat2", lane, 8'h32);
    #2;
    rstN = 1'b0;
    #1;
    chk("rstmid_lane", lane, 8'h00);
    chk("rstmid_active", act, 1'b0);
    chk("rstmid_cnt", cnt, 0);
    step();
    rstN = 1'b1;
    step();
    chk("rstmid_clk", clkData, 2'b10);
    bus.iValid = 1'b1; bus.iData = W;
    #1;
    chk("rstmid_ready", bus.oReady, 1'b1);
    step();
    bus.iValid = 1'b0;
    chk("rstmid_restart", lane, 8'h02);
    repeat (BEATS) step();
    chk("rstmid_cnt_end", cnt, 1);

    // Saturating counter on the 2-bit instance.
    doReset();
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.iValid = 1'b1; bus.iData = $urandom;
      step();
      bus.iValid = 1'b0;
      repeat (BEATS + 1) step();
      chk($sformatf("sat_cnt%0d", i), satCnt, (i < 3) ? i + 1 : 3);
      chk($sformatf("wide_cnt%0d", i), cnt, i + 1);
    end

    // Training request while idle, then raised mid-word.
    doReset();
    en = 1'b1; train = 1'b1;
    step();
    step();
    chk("train_idle_lane", lane, TRAIN ? 8'hAA : 8'h00);
    chk("train_idle_active", act, 1'b0);
    chk("train_idle_ready", bus.oReady, !TRAIN);
`ifdef PTI_TRAIN_PATTERN_EN
    bus.iValid = 1'b1; bus.iData = W;
    step();
    chk("train_block_lane", lane, 8'hAA);
    chk("train_block_active", act, 1'b0);
`endif
    train = 1'b0; bus.iValid = 1'b1; bus.iData = W;
    #1;
    chk("train_off_ready", bus.oReady, 1'b1);
    step();
    bus.iValid = 1'b0;
    train = 1'b1;
    chk("train_word_b0", lane, 8'h02);
    for (int b = 1; b < BEATS; b++) begin
      step();
      chk($sformatf("train_word_b%0d", b), lane, beatOf(W, b));
    end
    #1;
    chk("train_last_ready", bus.oReady, 1'b1);
    step();
    chk("train_after_word", lane, TRAIN ? 8'hAA : 8'h00);
    chk("train_after_active", act, 1'b0);

    // Random traffic against the beat-queue model.
    doReset();
    hold = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      en    = ($urandom_range(0, 7) != 0);
      train = ($urandom_range(0, 4) == 0);
      if (!hold) begin
        bus.iValid = ($urandom_range(0, 2) != 0);
        bus.iData  = $urandom;
      end
      #1;
      r = modelReady();
      chk("rnd_ready", bus.oReady, r);
      acc  = bus.iValid && r;
      hold = bus.iValid && !acc;
      modelEdge(acc);
      step();
      chk("rnd_lane", lane, mLane);
      chk("rnd_active", act, mActive);
      chk("rnd_cnt", cnt, mCnt);
      chk("rnd_satcnt", satCnt, mSat);
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end
endmodule
